// File: rtl/alu_exec_pipe.sv
// alu_exec_pipe: two-stage pipelined ALU execute stage.
//
// Stage 1 holds the accepted op and its operands. Stage 2 holds the
// computed result and flags, and drives the outputs directly, so nothing
// combinational runs from the op inputs to the outputs. Both stages
// advance under valid/ready, which gives one op per cycle when the
// consumer keeps up and loses nothing when it stalls.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   in_valid_i/in_ready_o   upstream handshake
//   alu_op_i, op_a_i, op_b_i  op code and operands (sampled on accept only)
//   out_valid_o/out_ready_i downstream handshake
//   result_o, carry_o, zero_o, overflow_o, illegal_op_o  stage-2 outputs
module alu_exec_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int SHAMT_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [3:0]            alu_op_i,
    input  logic [DATA_WIDTH-1:0] op_a_i,
    input  logic [DATA_WIDTH-1:0] op_b_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o,
    output logic                  zero_o,
    output logic                  overflow_o,
    output logic                  illegal_op_o
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0010;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_SHL = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;

    localparam int W = DATA_WIDTH;

    logic            s1_valid_q, s1_valid_d;
    logic [3:0]      s1_op_q;
    logic [W-1:0]    s1_a_q, s1_b_q;

    logic            s2_valid_q;
    logic [W-1:0]    result_q, result_d;
    logic            carry_q, carry_d;
    logic            zero_q, zero_d;
    logic            overflow_q, overflow_d;
    logic            illegal_q, illegal_d;

    logic            s2_adv, s1_adv, in_fire;

    logic [SHAMT_WIDTH-1:0] shamt;
    logic [W:0]             sum_w, diff_w, shl_w, shr_w;

    always_comb begin
        s2_adv     = !s2_valid_q || out_ready_i;
        s1_adv     = !s1_valid_q || s2_adv;
        in_fire    = in_valid_i && s1_adv;
        s1_valid_d = s1_adv ? in_valid_i : s1_valid_q;
    end

    assign in_ready_o = s1_adv;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_op_q <= alu_op_i;
                s1_a_q  <= op_a_i;
                s1_b_q  <= op_b_i;
            end
        end
    end

    // Shifts are done one bit wider so the bit pushed out lands in a fixed
    // position: bit W for SHL, bit 0 for SHR. With a zero shift that bit is
    // the zero padding, which gives carry = 0 for free.
    always_comb begin
        shamt  = s1_b_q[SHAMT_WIDTH-1:0];
        sum_w  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
        diff_w = {1'b0, s1_a_q} - {1'b0, s1_b_q};
        shl_w  = {1'b0, s1_a_q} << shamt;
        shr_w  = {s1_a_q, 1'b0} >> shamt;

        // Undefined op codes fall through to these ADD defaults.
        result_d   = sum_w[W-1:0];
        carry_d    = sum_w[W];
        overflow_d = (s1_a_q[W-1] == s1_b_q[W-1]) && (sum_w[W-1] != s1_a_q[W-1]);
        illegal_d  = 1'b0;

        case (s1_op_q)
            OP_ADD: ;
            OP_SUB: begin
                result_d   = diff_w[W-1:0];
                carry_d    = diff_w[W];
                overflow_d = (s1_a_q[W-1] != s1_b_q[W-1]) && (diff_w[W-1] != s1_a_q[W-1]);
            end
            OP_OR: begin
                result_d   = s1_a_q | s1_b_q;
                carry_d    = 1'b0;
                overflow_d = 1'b0;
            end
            OP_AND: begin
                result_d   = s1_a_q & s1_b_q;
                carry_d    = 1'b0;
                overflow_d = 1'b0;
            end
            OP_SHL: begin
                result_d   = shl_w[W-1:0];
                carry_d    = shl_w[W];
                overflow_d = 1'b0;
            end
            OP_SHR: begin
                result_d   = shr_w[W:1];
                carry_d    = shr_w[0];
                overflow_d = 1'b0;
            end
            default: illegal_d = 1'b1;
        endcase

        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                result_q   <= result_d;
                carry_q    <= carry_d;
                zero_q     <= zero_d;
                overflow_q <= overflow_d;
                illegal_q  <= illegal_d;
            end
        end
    end

    assign out_valid_o  = s2_valid_q;
    assign result_o     = result_q;
    assign carry_o      = carry_q;
    assign zero_o       = zero_q;
    assign overflow_o   = overflow_q;
    assign illegal_op_o = illegal_q;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// tb_alu_exec_pipe: directed bench for alu_exec_pipe (W = 16).
// Single-op vectors from a table, then reset, backpressure and throughput
// sequences. Inputs change 1 ns after the rising edge; streams sample at
// the falling edge.
module tb_alu_exec_pipe;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        o;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = 4'h0;
    logic [15:0] op_a = 16'h0;
    logic [15:0] op_b = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic        carry, zero, overflow, illegal_op;

    int tests = 0;
    int fails = 0;

    vec_t vecs[16];
    vec_t strm[8];

    always #5 clk = ~clk;

    alu_exec_pipe #(.DATA_WIDTH(16), .SHAMT_WIDTH(4)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .alu_op_i    (alu_op),
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .carry_o     (carry),
        .zero_o      (zero),
        .overflow_o  (overflow),
        .illegal_op_o(illegal_op)
    );

    function automatic vec_t mk(logic [3:0] op, logic [15:0] a, logic [15:0] b,
                                logic [15:0] r, logic c, logic z, logic o, logic ill);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.res = r;
        v.c = c; v.z = z; v.o = o; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] outs();
        return {result, carry, zero, overflow, illegal_op};
    endfunction

    function automatic logic [19:0] expv(vec_t v);
        return {v.res, v.c, v.z, v.o, v.ill};
    endfunction

    task automatic drive(input vec_t v);
        alu_op = v.op;
        op_a   = v.a;
        op_b   = v.b;
    endtask

    // Cycle-level stream: a scoreboard holds accepted ops in order, and the
    // in-flight count predicts in_ready (low only with two ops held and the
    // consumer stalled).
    task automatic run_stream(input int n, input int stall, input string tag);
        vec_t        sb[$];
        vec_t        e;
        int          issued = 0, delivered = 0, inflight = 0, stall_seen = 0;
        int          cyc = 0, first_acc = -1;
        bit          prev_stall = 0, saw_block = 0, acc, del;
        logic [19:0] prev_out = '0;

        out_ready = (stall == 0);
        drive(strm[0]);
        in_valid = 1'b1;
        while (delivered < n && cyc < 60) begin
            @(negedge clk);
            check({tag, "_in_ready"}, {31'b0, in_ready},
                  {31'b0, !(inflight == 2 && !out_ready)});
            if (!in_ready) saw_block = 1;
            if (prev_stall)
                check({tag, "_hold"}, {11'b0, out_valid, outs()}, {11'b0, 1'b1, prev_out});
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (acc) begin
                sb.push_back(strm[issued]);
                if (first_acc < 0) first_acc = cyc;
            end
            if (out_valid && !out_ready) stall_seen++;
            if (del) begin
                if (sb.size() == 0) begin
                    check({tag, "_spurious_beat"}, 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({tag, "_data"}, {12'b0, outs()}, {12'b0, expv(e)});
                    if (stall == 0)
                        check({tag, "_beat_cycle"}, cyc, first_acc + 2 + delivered);
                end
                delivered++;
            end
            if (acc) inflight++;
            if (del) inflight--;
            prev_stall = out_valid && !out_ready;
            prev_out   = outs();
            @(posedge clk);
            #1;
            if (acc) issued++;
            if (issued < n) drive(strm[issued]);
            in_valid  = (issued < n);
            out_ready = (stall_seen >= stall);
            cyc++;
        end
        check({tag, "_delivered"}, delivered, n);
        if (stall > 0) check({tag, "_saw_in_ready_low"}, {31'b0, saw_block}, 32'd1);
        out_ready = 1'b1;
        in_valid  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //             op     a        b        result   c     z     o     ill
        vecs[0]  = mk(4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[1]  = mk(4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mk(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(4'h4, 16'h8001, 16'h0011, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(4'h5, 16'h0003, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(4'h4, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(4'h2, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(4'h3, 16'hFF00, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[8]  = mk(4'h1, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(4'hA, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[10] = mk(4'h0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(4'h5, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[12] = mk(4'h4, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[13] = mk(4'h0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        vecs[14] = mk(4'hF, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
        vecs[15] = mk(4'h5, 16'h0005, 16'h0000, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #12;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_outputs", {12'b0, outs()}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single-op vectors, consumer always ready
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            check($sformatf("vec%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("vec%0d_not_early", i), {31'b0, out_valid}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            check($sformatf("vec%0d_data", i), {12'b0, outs()}, {12'b0, expv(vecs[i])});
        end
        @(posedge clk);
        #1;
        check("drain_idle", {31'b0, out_valid}, 32'd0);

        // Reset with both stages full and stalled
        out_ready = 1'b0;
        drive(mk(4'h0, 16'h0001, 16'h0002, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        drive(mk(4'h1, 16'h0009, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("full_in_ready_low", {31'b0, in_ready}, 32'd0);
        check("full_out_valid", {31'b0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        check("midrst_outputs", {12'b0, outs()}, 32'd0);
        check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        drive(mk(4'h0, 16'h0004, 16'h0005, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("postrst_not_early", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("postrst_valid", {31'b0, out_valid}, 32'd1);
        check("postrst_data", {12'b0, outs()}, {12'b0, 16'h0009, 4'b0000});
        @(posedge clk);
        #1;
        check("postrst_no_replay", {31'b0, out_valid}, 32'd0);

        // Backpressure: 3 stall cycles after first out_valid
        strm[0] = mk(4'h0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0);
        strm[1] = mk(4'h1, 16'h0005, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0);
        strm[2] = mk(4'h2, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0);
        strm[3] = mk(4'h3, 16'h00FF, 16'h000F, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
        run_stream(4, 3, "bp");
        @(posedge clk);
        #1;

        // Throughput: 8 back-to-back ops
        strm[0] = mk(4'h0, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0);
        strm[1] = mk(4'h1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        strm[2] = mk(4'h4, 16'h00C3, 16'h0004, 16'h0C30, 1'b0, 1'b0, 1'b0, 1'b0);
        strm[3] = mk(4'h5, 16'h00C3, 16'h0002, 16'h0030, 1'b1, 1'b0, 1'b0, 1'b0);
        strm[4] = mk(4'h7, 16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1);
        strm[5] = mk(4'h3, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        strm[6] = mk(4'h2, 16'hA000, 16'h000A, 16'hA00A, 1'b0, 1'b0, 1'b0, 1'b0);
        strm[7] = mk(4'h0, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0);
        run_stream(8, 0, "tp");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_pipe.md
Name: alu_exec_pipe

Overview:
- Two-stage pipelined ALU execute stage directly downstream of the opcode-to-ALU-op decoder. Consumes its 4-bit alu_op together with two operands.
- Computes the result and flags, and presents them under valid/ready handshakes on both sides.
- Supports full throughput (one op per cycle) with lossless backpressure toward the writeback/consumer stage.

Parameters:
- DATA_WIDTH, 16, operand/result width in bits (>= 4).
- SHAMT_WIDTH, 4, shift-amount bits taken from op_b; must equal log2(DATA_WIDTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents an op.
- in_ready  output  1  stage can accept an op this cycle.
- alu_op  input  4  0000 ADD, 0001 SUB, 0010 OR, 0011 AND, 0100 SHL, 0101 SHR.
- op_a  input  DATA_WIDTH  first operand.
- op_b  input  DATA_WIDTH  second operand / shift amount.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts this cycle.
- result  output  DATA_WIDTH  operation result.
- carry  output  1  carry/borrow/shifted-out bit.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow (ADD/SUB only).
- illegal_op  output  1  alu_op was outside 0000-0101.

Behaviour:
- Reset (async assert, deasserted synchronously by the environment):
  - s1_valid = s2_valid = 0.
  - All output registers = 0: result, carry, zero, overflow, illegal_op, out_valid.
  - Reset mid-operation discards all in-flight ops; nothing is replayed.
- Pipeline:
  - S1 captures alu_op/op_a/op_b on accept (in_valid && in_ready).
  - S2 registers the computed result and flags from S1.
  - Outputs are driven directly from S2 registers; no combinational path from inputs to outputs.
- Latency: an op accepted at edge N appears with out_valid=1 after edge N+1, provided S2 is free. Throughput is 1 op/cycle when out_ready=1 continuously.
- Handshake:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready and state; no dependence on in_valid).
  - When out_valid && !out_ready: result and all flags hold stable, out_valid stays 1, and no op is lost or duplicated.
  - With both stages full and stalled, in_ready = 0.
  - A simultaneous accept and output transfer in one cycle is legal: both stages shift.
  - in_valid may drop without a transfer; op inputs are sampled only on accept.
- Arithmetic (W = DATA_WIDTH; unsigned unless stated):
  - ADD: result = (a+b) mod 2^W. carry = bit W of a+b. overflow = a[W-1]==b[W-1] && result[W-1]!=a[W-1].
  - SUB: result = (a-b) mod 2^W. carry = borrow = (a < b). overflow = a[W-1]!=b[W-1] && result[W-1]!=a[W-1].
  - OR / AND: bitwise; carry = overflow = 0.
  - SHL: s = b[SHAMT_WIDTH-1:0]; result = a << s. carry = a[W-s] if s>0, else 0. Upper bits of b are ignored.
  - SHR (logical): result = a >> s. carry = a[s-1] if s>0, else 0.
  - zero = (result == 0) for every op.
  - Undefined alu_op (0110-1111): executed as ADD, with illegal_op=1 on that result beat only.
- No internal state beyond the two stages; no buffering beyond 2 entries.

Test Plan:
- Reset: assert rst mid-stream with both stages full -> next cycle out_valid=0, result=0, all flags 0, in_ready=1. After release, the first new op emerges 2 cycles after accept.
- Arithmetic edges, W=16:
  - ADD 0xFFFF+0x0001 -> result 0x0000, carry=1, zero=1, overflow=0.
  - ADD 0x7FFF+0x0001 -> result 0x8000, overflow=1, carry=0.
  - SUB 0x0003-0x0005 -> result 0xFFFE, carry=1.
- Shifts:
  - SHL 0x8001 by b=0x0011 (s=1) -> result 0x0002, carry=1.
  - SHR 0x0003 by 1 -> result 0x0001, carry=1.
  - SHL by 0 -> result = a, carry=0.
- Backpressure: stream 4 ops (ADD 1+1, SUB 5-2, OR 0xF0|0x0F, AND 0xFF&0x0F) with out_ready low for 3 cycles after the first out_valid -> in_ready=0 once both stages are full; outputs stable while stalled; the results 2, 3, 0x00FF, 0x000F emerge in order with no loss or duplication.
- Throughput: in_valid=1 and out_ready=1 for 8 consecutive ops -> 8 consecutive out_valid beats starting 2 cycles after the first accept, in_ready constantly 1.
- Illegal op: alu_op=4'b1010 with a=2, b=3 -> result 5, illegal_op=1. The following legal op gives illegal_op=0.
